// File: rtl/vga_sync_decode.sv
// VGA timing recovery: rebuilds pixel coordinates from hsync/vsync,
// tracks lock, and produces per-pixel strobes and a per-frame checksum.
module vga_sync_decode #(
  parameter int HD = 640,
  parameter int HF = 48,
  parameter int HB = 16,
  parameter int HR = 96,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VB = 33,
  parameter int VR = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  rgb_out,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);

  localparam int H_TOTAL = HD + HF + HB + HR;
  localparam int H_SS    = HD + HB;
  localparam int V_TOTAL = VD + VF + VB + VR;
  localparam int V_SS    = VD + VB;
  localparam int WD_MAX  = 2 * H_TOTAL;
  localparam int WW      = $clog2(WD_MAX + 1);

  localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC = 10'(H_SS);
  localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC = 10'(V_SS);
  localparam logic [9:0] X_LIM  = 10'(HD);
  localparam logic [9:0] Y_LIM  = 10'(VD);
  localparam logic [9:0] X_LAST = 10'(HD - 1);
  localparam logic [9:0] Y_LAST = 10'(VD - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_MAX - 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          hs_q;
  logic          vs_q;
  logic [WW-1:0] wd;
  logic [15:0]   acc;

  logic       hs_rise;
  logic       vs_rise;
  logic       h_last;
  logic       v_last;
  logic [9:0] h_pred;
  logic [9:0] v_adv;
  logic [9:0] v_pred;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       wd_hit;
  logic       err;
  logic       active;
  logic       show;
  logic       last_px;

  always_comb begin
    hs_rise = p_tick & hsync & ~hs_q;
    vs_rise = p_tick & vsync & ~vs_q;
    h_last  = (h_cnt == H_END);
    v_last  = (v_cnt == V_END);
    h_pred  = h_last ? 10'd0 : h_cnt + 10'd1;
    v_adv   = v_last ? 10'd0 : v_cnt + 10'd1;
    // free-running prediction ignores any hsync realignment
    v_pred  = h_last ? v_adv : v_cnt;
    h_nxt   = hs_rise ? H_SYNC : h_pred;
    if (vs_rise)
      v_nxt = V_SYNC;
    else if (h_last && !hs_rise)
      v_nxt = v_adv;
    else
      v_nxt = v_cnt;
    wd_hit  = !hs_rise && (wd == WD_LAST);
    err     = p_tick && (state != HUNT) &&
              ((hs_rise && h_pred != H_SYNC) ||
               (vs_rise && v_pred != V_SYNC) ||
               wd_hit);
    active  = (h_nxt < X_LIM) && (v_nxt < Y_LIM);
    show    = (state == LOCKED) && !err && active;
    last_px = (h_nxt == X_LAST) && (v_nxt == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      wd          <= '0;
      acc         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      rgb_out     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= '0;
      frame_sum   <= '0;
      sum_valid   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      sum_valid   <= 1'b0;
      if (p_tick) begin
        hs_q        <= hsync;
        vs_q        <= vsync;
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        pix_x       <= h_nxt;
        pix_y       <= v_nxt;
        rgb_out     <= show ? rgb : 3'd0;
        pix_valid   <= show;
        frame_start <= show && (h_nxt == 10'd0) && (v_nxt == 10'd0);
        if (err) begin
          state  <= HUNT;
          locked <= 1'b0;
          wd     <= '0;
          acc    <= '0;
          if (err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
        end else begin
          unique case (state)
            HUNT: begin
              wd <= '0;
              if (vs_rise)
                state <= VERIFY;
            end
            VERIFY: begin
              wd <= hs_rise ? '0 : wd + 1'b1;
              if (vs_rise) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
            LOCKED: begin
              wd <= hs_rise ? '0 : wd + 1'b1;
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
        if (show) begin
          if (last_px) begin
            frame_sum <= acc + 16'(rgb);
            acc       <= '0;
            sum_valid <= 1'b1;
          end else begin
            acc <= acc + 16'(rgb);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decode.sv
// Randomized bench for vga_sync_decode: a generated sync stream drives the
// DUT while a coordinate-level model predicts each sample's outputs.
module tb_vga_sync_decode;

  localparam int HD = 20;
  localparam int HF = 4;
  localparam int HB = 3;
  localparam int HR = 5;
  localparam int VD = 6;
  localparam int VF = 2;
  localparam int VB = 2;
  localparam int VR = 2;
  localparam int HT  = HD + HF + HB + HR;
  localparam int HSS = HD + HB;
  localparam int VT  = VD + VF + VB + VR;
  localparam int VSS = VD + VB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [2:0]  rgb = 3'd0;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  rgb_out;
  logic        pix_valid;
  logic        frame_start;
  logic        locked;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;
  logic        sum_valid;

  vga_sync_decode #(
    .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p_tick(p_tick),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .rgb_out(rgb_out),
    .pix_valid(pix_valid),
    .frame_start(frame_start),
    .locked(locked),
    .err_cnt(err_cnt),
    .frame_sum(frame_sum),
    .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk;
    logic        pv;
    logic        fs;
    logic        sv;
    logic [2:0]  c;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  e;
    logic [15:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pv_cnt = 0;
  int   fs_cnt = 0;
  int   sv_cnt = 0;
  bit   samp = 1'b0;

  // reference model state: receiver position, lock phase, counters
  int m_st, mx, my, mwd, merr, macc, msum;
  bit mhq, mvq;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; mx = 0; my = 0; mwd = 0;
    merr = 0; macc = 0; msum = 0;
    mhq = 0; mvq = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input int c);
    bit hr, vr, bad, valid;
    int fx, fy, nx, ny;
    exp_t e;
    hr = hs && !mhq;
    vr = vs && !mvq;
    mhq = hs;
    mvq = vs;
    fx = (mx + 1) % HT;
    fy = (mx == HT - 1) ? (my + 1) % VT : my;
    nx = hr ? HSS : fx;
    if (vr) ny = VSS;
    else if (mx == HT - 1 && !hr) ny = (my + 1) % VT;
    else ny = my;
    bad = 0;
    if (m_st != 0) begin
      if (hr) mwd = 0;
      else mwd++;
      bad = (hr && fx != HSS) || (vr && fy != VSS) || (mwd >= 2 * HT);
    end
    if (bad) begin
      m_st = 0;
      mwd = 0;
      macc = 0;
      if (merr < 255) merr++;
    end else if (vr && m_st < 2) begin
      m_st++;
    end
    mx = nx;
    my = ny;
    valid = (m_st == 2) && nx < HD && ny < VD;
    e = '0;
    if (valid) begin
      if (nx == HD - 1 && ny == VD - 1) begin
        msum = (macc + c) % 65536;
        macc = 0;
        e.sv = 1;
      end else begin
        macc = (macc + c) % 65536;
      end
    end
    e.lk = (m_st == 2);
    e.pv = valid;
    e.fs = valid && nx == 0 && ny == 0;
    e.c  = valid ? 3'(c) : 3'd0;
    e.x  = 10'(nx);
    e.y  = 10'(ny);
    e.e  = 8'(merr);
    e.s  = 16'(msum);
    sb.push_back(e);
  endtask

  // one pixel: p_tick high for one clk out of every two
  task automatic drive_pix(input bit hs, input bit vs, input int c);
    @(posedge clk);
    #1;
    p_tick = 1'b1;
    hsync = hs;
    vsync = vs;
    rgb = 3'(c);
    model_step(hs, vs, c);
    @(posedge clk);
    #1;
    p_tick = 1'b0;
  endtask

  always @(posedge clk) samp <= p_tick && !reset;

  always @(negedge clk) begin
    exp_t a, e;
    if (samp) begin
      a.lk = locked;
      a.pv = pix_valid;
      a.fs = frame_start;
      a.sv = sum_valid;
      a.c  = rgb_out;
      a.x  = pix_x;
      a.y  = pix_y;
      a.e  = err_cnt;
      a.s  = frame_sum;
      if (pix_valid) pv_cnt++;
      if (frame_start) fs_cnt++;
      if (sum_valid) sv_cnt++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sample: DUT output %h with no expected entry", a);
      end else begin
        e = sb.pop_front();
        if (a != e) begin
          n_fail++;
          $display("FAIL sample: got lk%0d pv%0d fs%0d sv%0d c%0d (%0d,%0d) e%0d s%0h, expected lk%0d pv%0d fs%0d sv%0d c%0d (%0d,%0d) e%0d s%0h",
                   a.lk, a.pv, a.fs, a.sv, a.c, a.x, a.y, a.e, a.s,
                   e.lk, e.pv, e.fs, e.sv, e.c, e.x, e.y, e.e, e.s);
        end
      end
    end else if (!reset) begin
      n_chk++;
      if (pix_valid || frame_start || sum_valid) begin
        n_fail++;
        $display("FAIL strobe_hold: got pv%0d fs%0d sv%0d, expected 0",
                 pix_valid, frame_start, sum_valid);
      end
    end
  end

  // mode 0 random clean, 1 hsync late on line 1, 2 hsync low lines 1-4,
  // 3 solid colour 5
  task automatic run_frame(input int mode, input int nlines);
    int e0, since;
    bit hs, vs, prev_hs, wd_done;
    int c;
    pv_cnt = 0;
    fs_cnt = 0;
    sv_cnt = 0;
    e0 = int'(err_cnt);
    since = 0;
    prev_hs = 0;
    wd_done = 0;
    for (int gy = 0; gy < nlines; gy++) begin
      for (int gx = 0; gx < HT; gx++) begin
        hs = (gx >= HSS) && (gx < HSS + HR);
        vs = (gy >= VSS) && (gy < VSS + VR);
        if (mode == 1 && gy == 1)
          hs = (gx >= HSS + 1) && (gx < HSS + HR + 1);
        if (mode == 2 && gy >= 1 && gy <= 4)
          hs = 0;
        c = (mode == 3) ? 5 : int'($urandom_range(0, 7));
        drive_pix(hs, vs, c);
        since = (hs && !prev_hs) ? 0 : since + 1;
        prev_hs = hs;
        if (mode == 1 && gy == 1 && gx == HSS)
          chk("pre_delay_locked", locked, 1);
        if (mode == 1 && gy == 1 && gx == HSS + 1) begin
          chk("delay_unlock", locked, 0);
          chk("delay_err_cnt", err_cnt, e0 + 1);
        end
        if (mode == 2 && !wd_done && since == 2 * HT - 1)
          chk("wd_edge_locked", locked, 1);
        if (mode == 2 && !wd_done && since == 2 * HT) begin
          chk("wd_unlock", locked, 0);
          chk("wd_err_cnt", err_cnt, e0 + 1);
          wd_done = 1;
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_misc"},
        {rgb_out, pix_valid, frame_start, frame_sum, sum_valid}, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    run_frame(0, VT);
    chk("f0_locked", locked, 0);
    run_frame(0, VT);
    chk("f1_locked", locked, 1);
    chk("f1_pv_cnt", pv_cnt, 0);
    run_frame(0, VT);
    chk("f2_pv_cnt", pv_cnt, HD * VD);
    chk("f2_fs_cnt", fs_cnt, 1);
    chk("f2_sv_cnt", sv_cnt, 1);
    run_frame(3, VT);
    chk("solid_sum", frame_sum, (5 * HD * VD) % 65536);
    chk("solid_sv_cnt", sv_cnt, 1);

    run_frame(1, VT);
    chk("delay_f_locked", locked, 0);
    chk("delay_f_err", err_cnt, 1);
    run_frame(0, VT);
    chk("relock1_locked", locked, 1);
    run_frame(0, VT);
    chk("relock1_pv_cnt", pv_cnt, HD * VD);
    chk("relock1_err", err_cnt, 1);

    run_frame(2, VT);
    chk("wd_f_err", err_cnt, 2);
    run_frame(0, VT);
    chk("relock2_locked", locked, 1);
    run_frame(0, 3);
    chk("pre_reset_locked", locked, 1);

    @(posedge clk);
    #1;
    reset = 1'b1;
    p_tick = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    reset = 1'b0;
    p_tick = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    model_reset();

    for (int i = 0; i < 300; i++) begin
      drive_pix(0, 1, 0);
      drive_pix(1, 0, 0);
      drive_pix(0, 0, 0);
      if (i == 253) begin
        @(negedge clk);
        chk("loss_254", err_cnt, 254);
      end
    end
    @(negedge clk);
    #1;
    chk("loss_sat", err_cnt, 255);
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decode.md
VGA_SYNC_DECODE -- requirements
Module: vga_sync_decode

Interface
Parameters:
REQ-001 The block SHALL have parameter HD, default 640, meaning horizontal display pixels.
REQ-002 The block SHALL have parameter HF, default 48, meaning left border pixels.
REQ-003 The block SHALL have parameter HB, default 16, meaning right border pixels.
REQ-004 The block SHALL have parameter HR, default 96, meaning horizontal retrace pixels.
REQ-005 The block SHALL have parameter VD, default 480, meaning display lines.
REQ-006 The block SHALL have parameter VF, default 10, meaning top border lines.
REQ-007 The block SHALL have parameter VB, default 33, meaning bottom border lines.
REQ-008 The block SHALL have parameter VR, default 2, meaning vertical retrace lines.
Ports:
REQ-009 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-010 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-011 The block SHALL have port p_tick, input, 1 bit: pixel enable; hsync, vsync and rgb are sampled only when it is 1.
REQ-012 The block SHALL have port hsync, input, 1 bit, and port vsync, input, 1 bit: active-high sync inputs.
REQ-013 The block SHALL have port rgb, input, 3 bits: incoming pixel colour.
REQ-014 The block SHALL have ports pix_x and pix_y, output, 10 bits each: recovered pixel coordinates.
REQ-015 The block SHALL have port rgb_out, output, 3 bits: sampled colour; 0 outside the active area.
REQ-016 The block SHALL have port pix_valid, output, 1 bit: 1-clk strobe for each active pixel while locked.
REQ-017 The block SHALL have port frame_start, output, 1 bit: 1-clk strobe on pixel (0,0) while locked.
REQ-018 The block SHALL have port locked, output, 1 bit: timing lock indicator.
REQ-019 The block SHALL have port err_cnt, output, 8 bits: saturating count of lock losses.
REQ-020 The block SHALL have ports frame_sum, output, 16 bits, and sum_valid, output, 1 bit: per-frame rgb checksum and its strobe.

Function
REQ-021 Derived constants: H_TOTAL=HD+HF+HB+HR (800), H_SS=HD+HB (656), V_TOTAL=VD+VF+VB+VR (525), V_SS=VD+VB (513).
REQ-022 On each p_tick the block SHALL register hs_q<=hsync and vs_q<=vsync; hs_rise=p_tick&hsync&~hs_q and vs_rise=p_tick&vsync&~vs_q.
REQ-023 On each p_tick, h_cnt SHALL load H_SS on hs_rise, wrap H_TOTAL-1->0, else +1; hs_rise wins over wrap.
REQ-024 v_cnt SHALL advance on h_cnt wrap (V_TOTAL-1->0) and load V_SS on vs_rise; vs_rise wins.
REQ-025 The FSM SHALL have states HUNT (reset state), VERIFY and LOCKED; locked=1 only in LOCKED.
REQ-026 HUNT->VERIFY SHALL occur on vs_rise.
REQ-027 VERIFY->LOCKED SHALL occur on the next vs_rise with no error since VERIFY was entered.
REQ-028 In VERIFY or LOCKED, an error SHALL be: hs_rise with the free-run predicted h_cnt != H_SS; or vs_rise with predicted v_cnt != V_SS; or watchdog reaching 2*H_TOTAL p_ticks without hs_rise.
REQ-029 On error the FSM SHALL go to HUNT on that clk edge and err_cnt SHALL increment, saturating at 255.
REQ-030 The watchdog SHALL clear on hs_rise and be idle in HUNT.
REQ-031 Outputs SHALL be registered one clk after the sampling p_tick and SHALL hold between p_ticks.
REQ-032 pix_x/pix_y SHALL be the h_cnt/v_cnt of the sample.
REQ-033 rgb_out SHALL be the sampled rgb when locked and h_cnt<HD and v_cnt<VD, else 0.
REQ-034 pix_valid SHALL pulse under the same condition as REQ-033.
REQ-035 An accumulator SHALL add rgb (zero-extended, mod 2^16) for each pix_valid sample.
REQ-036 At sample (HD-1,VD-1), frame_sum SHALL be set to acc+rgb, acc SHALL clear, and sum_valid SHALL pulse.
REQ-037 acc SHALL clear whenever the FSM leaves LOCKED.

Reset
REQ-038 While reset=1 at a clk edge, the state SHALL become HUNT and all counters, hs_q, vs_q, acc and every output SHALL become 0, including mid-frame; this overrides p_tick.

Verification
REQ-039 The bench SHALL drive clean 640x480 timing with p_tick every 2nd clk -> locked rises at 2nd vs_rise; frame_start then at each (0,0); exactly 307200 pix_valid per frame.
REQ-040 The bench SHALL drive a solid frame with rgb=3'b101 while locked -> frame_sum=0x7000 (1536000 mod 65536) with sum_valid.
REQ-041 The bench SHALL delay one hsync by 1 pixel while locked -> locked=0 one clk after that p_tick, err_cnt +1, relock after two further vs_rise.
REQ-042 The bench SHALL hold hsync low while locked -> lock lost after 1600 p_ticks, err_cnt +1.
REQ-043 The bench SHALL assert reset mid-frame while locked -> next clk: locked=0, pix_x=pix_y=0, err_cnt=0, state HUNT.
REQ-044 The bench SHALL force 300 lock losses -> err_cnt=255 and holds at 255.
